// File: rtl/needle_heystack_framer.sv
// Serializes a parallel needle word (MS byte first) followed by a heystack byte
// stream into one request frame on a registered 8-bit valid/last byte bus.
module needle_heystack_framer #(
   parameter int STRING_SIZE = 40
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [STRING_SIZE*8-1:0] needle,
   input  logic                     needle_valid,
   output logic                     needle_ready,
   input  logic [7:0]               heystack_data,
   input  logic                     heystack_valid,
   input  logic                     heystack_last,
   output logic                     heystack_ready,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   output logic                     out_last,
   input  logic                     out_ready
);

   localparam int NW = STRING_SIZE * 8;
   localparam int CW = $clog2(STRING_SIZE) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(STRING_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      NEEDLE   = 2'd1,
      HEYSTACK = 2'd2
   } state_e;

   state_e          state_q,     state_d;
   logic [CW-1:0]   count_q,     count_d;
   logic [NW-1:0]   needle_sr_q, needle_sr_d;
   logic [7:0]      out_data_q,  out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q,  out_last_d;
   logic            needle_rdy;
   logic            heystack_rdy;
   logic            slot_free;

   assign slot_free = !out_valid_q || out_ready;

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path infers a latch.
      state_d      = state_q;
      count_d      = count_q;
      needle_sr_d  = needle_sr_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      needle_rdy   = 1'b0;
      heystack_rdy = 1'b0;

      // A byte taken by downstream empties the slot even while frozen; a load below overrides.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      if (enable && slot_free) begin
         unique case (state_q)
            IDLE: begin
               needle_rdy = 1'b1;
               if (needle_valid) begin
                  out_data_d  = needle[NW-1 -: 8];
                  out_valid_d = 1'b1;
                  out_last_d  = 1'b0;
                  needle_sr_d = needle << 8;
                  count_d     = CW'(1);
                  state_d     = (STRING_SIZE == 1) ? HEYSTACK : NEEDLE;
               end
            end
            NEEDLE: begin
               out_data_d  = needle_sr_q[NW-1 -: 8];
               out_valid_d = 1'b1;
               out_last_d  = 1'b0;
               needle_sr_d = needle_sr_q << 8;
               count_d     = count_q + CW'(1);
               if (count_q == LAST_IDX) begin
                  state_d = HEYSTACK;
               end
            end
            HEYSTACK: begin
               heystack_rdy = 1'b1;
               if (heystack_valid) begin
                  out_data_d  = heystack_data;
                  out_valid_d = 1'b1;
                  out_last_d  = heystack_last;
                  if (heystack_last) begin
                     state_d = IDLE;
                     count_d = '0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         needle_sr_q <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         needle_sr_q <= needle_sr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   // Readys are forced low while reset is held, not just after the next edge.
   assign needle_ready   = needle_rdy & reset;
   assign heystack_ready = heystack_rdy & reset;

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_needle_heystack_framer.sv
// Self-checking bench for needle_heystack_framer: directed frames plus randomized
// traffic scored against a queue-based model of the framed byte stream.
module tb_needle_heystack_framer;

   localparam int SS = 4;

   logic            clock = 1'b0;
   logic            reset;
   logic            enable;
   logic [SS*8-1:0] needle;
   logic            needle_valid;
   logic            needle_ready;
   logic [7:0]      heystack_data;
   logic            heystack_valid;
   logic            heystack_last;
   logic            heystack_ready;
   logic [7:0]      out_data;
   logic            out_valid;
   logic            out_last;
   logic            out_ready;

   always #5 clock = ~clock;

   needle_heystack_framer #(.STRING_SIZE(SS)) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .needle         (needle),
      .needle_valid   (needle_valid),
      .needle_ready   (needle_ready),
      .heystack_data  (heystack_data),
      .heystack_valid (heystack_valid),
      .heystack_last  (heystack_last),
      .heystack_ready (heystack_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_last       (out_last),
      .out_ready      (out_ready)
   );

   typedef struct {
      logic [7:0] data;
      logic       last;
   } byte_t;

   logic [SS*8-1:0] nq[$];
   byte_t           hq[$];
   byte_t           exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Model of the frame at the handshake level.
   bit   in_frame;
   int   pend;
   int   cyc;
   int   xfers;
   int   rdy_mode;
   int   pat_idx;
   bit   hv_rand;
   bit   en_rand;
   bit   no_gap;
   bit   check_turn;
   bit   expect_valid_next;
   int   last_xfer_cyc;
   int   last_hlast_cyc;
   bit   prev_ok;
   bit   prev_valid;
   bit   prev_ready;
   bit   prev_en;
   bit   prev_last;
   logic [7:0] prev_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic observe();
      bit nh, hh, oh, free;
      logic [SS*8-1:0] nv;
      byte_t e;
      cyc++;
      free = (out_valid !== 1'b1) || out_ready;
      check("needle_ready", 32'(needle_ready), 32'(enable && !in_frame && free));
      check("heystack_ready", 32'(heystack_ready), 32'(enable && in_frame && pend == 0 && free));
      if (prev_ok && prev_valid && !prev_ready) begin
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_data", 32'(out_data), 32'(prev_data));
         check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (prev_ok && !prev_en) begin
         check("freeze_no_load", 32'(out_valid), 32'(prev_valid && !prev_ready));
      end
      if (expect_valid_next) begin
         check("needle_latency", 32'(out_valid), 32'd1);
         expect_valid_next = 1'b0;
      end

      nh = needle_valid && (needle_ready === 1'b1);
      hh = heystack_valid && (heystack_ready === 1'b1);
      oh = (out_valid === 1'b1) && out_ready;

      if (oh) begin
         check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_last", 32'(out_last), 32'(e.last));
         end
         if (no_gap && last_xfer_cyc >= 0) begin
            check("no_gap", 32'(cyc), 32'(last_xfer_cyc + 1));
         end
         last_xfer_cyc = cyc;
         xfers++;
      end

      if (in_frame && pend > 0 && enable && free) pend--;

      if (nh) begin
         nv = nq.pop_front();
         if (check_turn && last_hlast_cyc >= 0) begin
            check("accept_turnaround", 32'(cyc), 32'(last_hlast_cyc + 1));
         end
         for (int i = 0; i < SS; i++) begin
            exp_q.push_back('{data: nv[SS*8-1-8*i -: 8], last: 1'b0});
         end
         in_frame          = 1'b1;
         pend              = SS - 1;
         expect_valid_next = 1'b1;
      end

      if (hh) begin
         e = hq.pop_front();
         exp_q.push_back(e);
         if (e.last) begin
            in_frame       = 1'b0;
            last_hlast_cyc = cyc;
         end
      end

      prev_ok    = 1'b1;
      prev_valid = (out_valid === 1'b1);
      prev_ready = out_ready;
      prev_en    = enable;
      prev_data  = out_data;
      prev_last  = out_last;
   endtask

   // Entered and left at posedge+1: drive, observe at negedge, advance.
   task automatic cycle();
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (pat_idx % 3 == 0);
         default: out_ready = 1'($urandom_range(1));
      endcase
      pat_idx++;
      if (en_rand) enable = ($urandom_range(7) != 0);
      needle_valid = (nq.size() != 0);
      if (nq.size() != 0) needle = nq[0];
      heystack_valid = (hq.size() != 0) && (!hv_rand || $urandom_range(3) != 0);
      if (hq.size() != 0) begin
         heystack_data = hq[0].data;
         heystack_last = hq[0].last;
      end else begin
         heystack_last = 1'b0;
      end
      @(negedge clock);
      observe();
      @(posedge clock);
      #1;
   endtask

   task automatic run_until_done(input int budget);
      int n;
      n = 0;
      while ((nq.size() != 0 || hq.size() != 0 || exp_q.size() != 0) && n < budget) begin
         cycle();
         n++;
      end
      check("drain_timeout", 32'(nq.size() + hq.size() + exp_q.size()), 32'd0);
   endtask

   task automatic push_frame(input logic [SS*8-1:0] nv, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2, input int nb);
      logic [7:0] bs[3];
      bs[0] = b0; bs[1] = b1; bs[2] = b2;
      nq.push_back(nv);
      for (int i = 0; i < nb; i++) hq.push_back('{data: bs[i], last: (i == nb - 1)});
   endtask

   initial begin
      int x0, n;
      reset = 1'b0; enable = 1'b1; needle = '0; needle_valid = 1'b0;
      heystack_data = '0; heystack_valid = 1'b0; heystack_last = 1'b0; out_ready = 1'b0;
      in_frame = 0; pend = 0; cyc = 0; xfers = 0; rdy_mode = 0; pat_idx = 0;
      hv_rand = 0; en_rand = 0; no_gap = 0; check_turn = 0; expect_valid_next = 0;
      last_xfer_cyc = -1; last_hlast_cyc = -1; prev_ok = 0;
      prev_valid = 0; prev_ready = 0; prev_en = 1; prev_last = 0; prev_data = '0;

      repeat (2) @(posedge clock);
      #1;
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_needle_ready", 32'(needle_ready), 32'd0);
      check("rst_heystack_ready", 32'(heystack_ready), 32'd0);
      reset = 1'b1;

      // 1: basic frame, no bubbles
      rdy_mode = 0; no_gap = 1; last_xfer_cyc = -1; x0 = xfers;
      push_frame(32'h6162_6364, 8'h78, 8'h61, 8'h62, 3);
      run_until_done(50);
      check("t1_count", 32'(xfers - x0), 32'd7);

      // 2: backpressure 1,0,0 pattern
      rdy_mode = 1; pat_idx = 0; no_gap = 0; x0 = xfers;
      push_frame(32'h6162_6364, 8'h78, 8'h61, 8'h62, 3);
      run_until_done(100);
      check("t2_count", 32'(xfers - x0), 32'd7);

      // 3: second needle offered mid-frame
      rdy_mode = 0; no_gap = 1; last_xfer_cyc = -1; last_hlast_cyc = -1; check_turn = 1;
      push_frame(32'h6162_6364, 8'h78, 8'h61, 8'h62, 3);
      push_frame(32'h1122_3344, 8'h55, 8'h66, 8'h00, 2);
      run_until_done(100);
      check_turn = 0; no_gap = 0;

      // 4: async reset after two needle bytes
      x0 = xfers; n = 0;
      push_frame(32'hDEAD_BEEF, 8'h01, 8'h02, 8'h00, 2);
      while (xfers - x0 < 2 && n < 20) begin
         cycle();
         n++;
      end
      check("t4_setup", 32'(xfers - x0), 32'd2);
      #2;
      reset = 1'b0;
      #1;
      check("t4_async_data", 32'(out_data), 32'd0);
      check("t4_async_valid", 32'(out_valid), 32'd0);
      check("t4_async_last", 32'(out_last), 32'd0);
      check("t4_async_nrdy", 32'(needle_ready), 32'd0);
      check("t4_async_hrdy", 32'(heystack_ready), 32'd0);
      nq.delete(); hq.delete(); exp_q.delete();
      in_frame = 0; pend = 0; prev_ok = 0; expect_valid_next = 0;
      needle_valid = 1'b0; heystack_valid = 1'b0; heystack_last = 1'b0;
      @(posedge clock);
      #1;
      check("t4_held_valid", 32'(out_valid), 32'd0);
      reset = 1'b1;
      push_frame(32'hA1B2_C3D4, 8'hE5, 8'h00, 8'h00, 1);
      run_until_done(50);

      // 5: enable freeze mid-heystack
      push_frame($urandom(), 8'h10, 8'h20, 8'h30, 3);
      hq.push_back('{data: 8'h40, last: 1'b0});
      hq[2].last = 1'b0;
      hq.push_back('{data: 8'h50, last: 1'b1});
      n = 0;
      while (hq.size() > 3 && n < 30) begin
         cycle();
         n++;
      end
      check("t5_mid_heystack", 32'(in_frame && pend == 0), 32'd1);
      enable = 1'b0; x0 = xfers;
      repeat (5) cycle();
      check("t5_freeze_xfers", 32'(xfers - x0 <= 1), 32'd1);
      enable = 1'b1;
      run_until_done(50);

      // 6: single-byte heystack, then back in idle
      push_frame(32'h0000_0000, 8'hFF, 8'h00, 8'h00, 1);
      run_until_done(50);
      cycle();
      #4;
      check("t6_idle_ready", 32'(needle_ready), 32'd1);

      // Randomized frames with random backpressure, gaps and enable
      rdy_mode = 2; hv_rand = 1; en_rand = 1;
      for (int f = 0; f < 40; f++) begin
         int nb;
         nq.push_back($urandom());
         nb = $urandom_range(5, 1);
         for (int i = 0; i < nb; i++) hq.push_back('{data: 8'($urandom()), last: (i == nb - 1)});
      end
      run_until_done(5000);
      en_rand = 0; enable = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
